// File: rtl/wb_retire_queue.sv
// Write-back stage: holds one instruction, commits it to the GPR file / exception / ertn
// logic, and records every retired instruction in a small retire-trace FIFO.
module wb_retire_queue #(
  parameter int DATA_W      = 32,
  parameter int AREG_W      = 5,
  parameter int EXC_N       = 6,
  parameter int TRACE_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_valid,
  output logic                       wb_allowin,
  input  logic [31:0]                mem_pc,
  input  logic                       mem_gr_we,
  input  logic [AREG_W-1:0]          mem_waddr,
  input  logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_csr_re,
  input  logic [EXC_N-1:0]           mem_exc,
  input  logic                       mem_ertn,
  input  logic [DATA_W-1:0]          csr_rvalue,
  output logic                       rf_we,
  output logic [AREG_W-1:0]          rf_waddr,
  output logic [DATA_W-1:0]          rf_wdata,
  output logic                       wb_ex,
  output logic [$clog2(EXC_N)-1:0]   wb_exc_idx,
  output logic                       ertn_flush,
  output logic [31:0]                wb_pc,
  output logic                       trace_valid,
  input  logic                       trace_ready,
  output logic [31:0]                trace_pc,
  output logic [3:0]                 trace_we,
  output logic [AREG_W-1:0]          trace_waddr,
  output logic [DATA_W-1:0]          trace_wdata
);

  localparam int PTR_W = $clog2(TRACE_DEPTH);
  localparam int CNT_W = $clog2(TRACE_DEPTH + 1);
  localparam int IDX_W = $clog2(EXC_N);

  logic              wb_valid_reg, wb_valid_next;
  logic [31:0]       wb_pc_reg;
  logic              wb_gr_we_reg;
  logic [AREG_W-1:0] wb_waddr_reg;
  logic [DATA_W-1:0] wb_wdata_reg;
  logic              wb_csr_re_reg;
  logic [EXC_N-1:0]  wb_exc_reg;
  logic              wb_ertn_reg;

  logic [CNT_W-1:0]  count_reg, count_next;
  logic [PTR_W-1:0]  head_reg, head_next;
  logic [PTR_W-1:0]  tail_reg, tail_next;

  logic [31:0]       pc_mem    [TRACE_DEPTH];
  logic              we_mem    [TRACE_DEPTH];
  logic [AREG_W-1:0] waddr_mem [TRACE_DEPTH];
  logic [DATA_W-1:0] wdata_mem [TRACE_DEPTH];

  logic trace_pop, trace_full, retire_go, exc_any, flush, load;

  always_comb begin
    trace_pop   = (count_reg != '0) & trace_ready;
    trace_full  = (count_reg == CNT_W'(TRACE_DEPTH));
    // Reset suppresses retirement so a mid-operation reset never emits a commit pulse.
    retire_go   = wb_valid_reg & ~rst & (~trace_full | trace_pop);
    wb_allowin  = ~wb_valid_reg | retire_go;
    exc_any     = |wb_exc_reg;
    rf_we       = retire_go & wb_gr_we_reg & ~exc_any;
    rf_waddr    = wb_waddr_reg;
    rf_wdata    = wb_csr_re_reg ? csr_rvalue : wb_wdata_reg;
    wb_ex       = retire_go & exc_any;
    ertn_flush  = retire_go & wb_ertn_reg & ~exc_any;
    flush       = wb_ex | ertn_flush;
    load        = mem_valid & wb_allowin & ~flush;
    wb_pc       = wb_pc_reg;
    trace_valid = (count_reg != '0);
  end

  // Bit 0 wins: scan from the top so the lowest set bit is the last assignment.
  always_comb begin
    wb_exc_idx = '0;
    for (int i = EXC_N - 1; i >= 0; i--) begin
      if (wb_exc_reg[i]) wb_exc_idx = IDX_W'(i);
    end
  end

  always_comb begin
    wb_valid_next = wb_valid_reg;
    if (flush)           wb_valid_next = 1'b0;
    else if (wb_allowin) wb_valid_next = mem_valid;

    head_next  = trace_pop ? head_reg + PTR_W'(1) : head_reg;
    tail_next  = retire_go ? tail_reg + PTR_W'(1) : tail_reg;
    count_next = count_reg;
    if (retire_go & ~trace_pop)      count_next = count_reg + CNT_W'(1);
    else if (~retire_go & trace_pop) count_next = count_reg - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_reg <= 1'b0;
      count_reg    <= '0;
      head_reg     <= '0;
      tail_reg     <= '0;
    end else begin
      wb_valid_reg <= wb_valid_next;
      count_reg    <= count_next;
      head_reg     <= head_next;
      tail_reg     <= tail_next;
    end
  end

  // Payload needs no reset: it is only observed while wb_valid_reg is set.
  always_ff @(posedge clk) begin
    if (load) begin
      wb_pc_reg     <= mem_pc;
      wb_gr_we_reg  <= mem_gr_we;
      wb_waddr_reg  <= mem_waddr;
      wb_wdata_reg  <= mem_wdata;
      wb_csr_re_reg <= mem_csr_re;
      wb_exc_reg    <= mem_exc;
      wb_ertn_reg   <= mem_ertn;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < TRACE_DEPTH; gi++) begin : g_trace_entry
      always_ff @(posedge clk) begin
        if (retire_go && tail_reg == PTR_W'(gi)) begin
          pc_mem[gi]    <= wb_pc_reg;
          we_mem[gi]    <= rf_we;
          waddr_mem[gi] <= wb_waddr_reg;
          wdata_mem[gi] <= rf_wdata;
        end
      end
    end
  endgenerate

  // Head entry is presented combinationally so the consumer sees it in the same cycle.
  assign trace_pc    = pc_mem[head_reg];
  assign trace_we    = {4{we_mem[head_reg]}};
  assign trace_waddr = waddr_mem[head_reg];
  assign trace_wdata = wdata_mem[head_reg];

endmodule

// File: tb/tb_wb_retire_queue.sv
// Bench for wb_retire_queue: fixed vector table, corner-case sequences and randomized
// traffic, all checked against a queue-based behavioural model.
module tb_wb_retire_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, mem_valid, mem_gr_we, mem_csr_re, mem_ertn, trace_ready;
  logic [31:0] mem_pc, mem_wdata, csr_rvalue;
  logic [4:0]  mem_waddr;
  logic [5:0]  mem_exc;
  logic        wb_allowin, rf_we, wb_ex, ertn_flush, trace_valid;
  logic [4:0]  rf_waddr, trace_waddr;
  logic [31:0] rf_wdata, wb_pc, trace_pc, trace_wdata;
  logic [2:0]  wb_exc_idx;
  logic [3:0]  trace_we;

  always #5 clk = ~clk;

  wb_retire_queue #(.DATA_W(32), .AREG_W(5), .EXC_N(6), .TRACE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .wb_allowin(wb_allowin),
    .mem_pc(mem_pc), .mem_gr_we(mem_gr_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_csr_re(mem_csr_re), .mem_exc(mem_exc), .mem_ertn(mem_ertn), .csr_rvalue(csr_rvalue),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_ex(wb_ex),
    .wb_exc_idx(wb_exc_idx), .ertn_flush(ertn_flush), .wb_pc(wb_pc),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_pc(trace_pc),
    .trace_we(trace_we), .trace_waddr(trace_waddr), .trace_wdata(trace_wdata)
  );

  typedef struct {
    logic [31:0] pc; logic gr_we; logic [4:0] waddr; logic [31:0] wdata;
    logic csr_re; logic [5:0] exc; logic ertn;
  } instr_t;
  typedef struct { logic [31:0] pc; logic we; logic [4:0] waddr; logic [31:0] wdata; } trace_t;

  typedef struct {
    logic mv; logic gw; logic [4:0] wa; logic [31:0] wd; logic csr; logic [5:0] exc;
    logic ertn; logic [31:0] crv; logic tr;
    logic e_allow; logic e_rfwe; logic [4:0] e_wa; logic [31:0] e_wd; logic e_ex;
    logic [2:0] e_idx; logic e_ertn; logic e_tv; logic [3:0] e_twe; logic [31:0] e_twd;
  } vec_t;

  int n_cmp = 0, n_bad = 0, cyc = 0;

  // Reference model state: one WB slot and the trace FIFO as a queue.
  logic   m_wbv;
  instr_t m_wb;
  trace_t tq[$];
  logic   m_pop, m_go, m_allow, m_rfwe, m_ex, m_ertn;
  logic [31:0] m_wd;
  logic [2:0]  m_idx;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic settle();
    logic exc_any, found;
    #1;
    m_pop   = (tq.size() != 0) && trace_ready;
    m_go    = !rst && m_wbv && (tq.size() != DEPTH || m_pop);
    m_allow = !m_wbv || m_go;
    exc_any = (m_wb.exc != 6'd0);
    m_rfwe  = m_go && m_wb.gr_we && !exc_any;
    m_wd    = m_wb.csr_re ? csr_rvalue : m_wb.wdata;
    m_ex    = m_go && exc_any;
    m_ertn  = m_go && m_wb.ertn && !exc_any;
    m_idx   = 3'd0;
    found   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (!found && m_wb.exc[i]) begin m_idx = 3'(i); found = 1'b1; end
    end
    chk("allowin", wb_allowin, m_allow);
    chk("rf_we", rf_we, m_rfwe);
    chk("wb_ex", wb_ex, m_ex);
    chk("ertn_flush", ertn_flush, m_ertn);
    chk("trace_valid", trace_valid, tq.size() != 0);
    if (m_rfwe) begin
      chk("rf_waddr", rf_waddr, m_wb.waddr);
      chk("rf_wdata", rf_wdata, m_wd);
    end
    if (m_ex) chk("wb_exc_idx", wb_exc_idx, m_idx);
    if (m_wbv && !rst) chk("wb_pc", wb_pc, m_wb.pc);
    if (tq.size() != 0) begin
      chk("trace_pc", trace_pc, tq[0].pc);
      chk("trace_we", trace_we, {4{tq[0].we}});
      chk("trace_waddr", trace_waddr, tq[0].waddr);
      chk("trace_wdata", trace_wdata, tq[0].wdata);
    end
    $display("cyc %0d rst=%b mv=%b allow=%b go=%b rf_we=%b ex=%b ertn=%b tv=%b pop=%b cnt=%0d",
             cyc, rst, mem_valid, wb_allowin, m_go, rf_we, wb_ex, ertn_flush, trace_valid,
             m_pop, tq.size());
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      m_wbv = 1'b0;
      tq.delete();
    end else begin
      if (m_pop) void'(tq.pop_front());
      if (m_go) tq.push_back('{m_wb.pc, m_rfwe, m_wb.waddr, m_wd});
      if (m_ex || m_ertn) m_wbv = 1'b0;
      else if (m_allow) begin
        m_wbv = mem_valid;
        if (mem_valid)
          m_wb = '{mem_pc, mem_gr_we, mem_waddr, mem_wdata, mem_csr_re, mem_exc, mem_ertn};
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_instr(input logic v, input logic [31:0] pc, input logic gw,
                           input logic [4:0] wa, input logic [31:0] wd);
    mem_valid = v; mem_pc = pc; mem_gr_we = gw; mem_waddr = wa; mem_wdata = wd;
    mem_csr_re = 1'b0; mem_exc = 6'd0; mem_ertn = 1'b0;
  endtask

  // Issue five instructions with the trace consumer stalled; the fifth ends up held in WB.
  task automatic fill5();
    int k = 0;
    for (int c = 0; c < 20 && k < 5; c++) begin
      set_instr(1'b1, 32'h2000 + 32'(4 * k), 1'b1, 5'(k + 1), 32'hA0 + 32'(k));
      trace_ready = 1'b0;
      settle();
      if (m_allow) k++;
      advance();
    end
    chk("fill5_issued", k, 5);
    set_instr(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  vec_t tbl[13];
  int   pops, got_n, issued;
  logic [31:0] got[16];

  initial begin
    rst = 1'b1; trace_ready = 1'b0; csr_rvalue = 32'h0;
    set_instr(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    m_wbv = 1'b0; m_wb = '{32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 6'd0, 1'b0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    //         mv   gw   wa    wd            csr  exc         ertn crv            tr
    //         allow rfwe wa   wd            ex   idx  ertn tv   twe    twd
    tbl[0]  = '{1'b0,1'b0,5'd0,32'h0,        1'b0,6'b000000,1'b0,32'h0,        1'b0,
                1'b1,1'b0,5'd0,32'h0,        1'b0,3'd0,1'b0,1'b0,4'h0,32'h0};
    tbl[1]  = '{1'b1,1'b1,5'd3,32'h1234,     1'b0,6'b000000,1'b0,32'h0,        1'b1,
                1'b1,1'b0,5'd0,32'h0,        1'b0,3'd0,1'b0,1'b0,4'h0,32'h0};
    tbl[2]  = '{1'b0,1'b0,5'd0,32'h0,        1'b0,6'b000000,1'b0,32'h0,        1'b1,
                1'b1,1'b1,5'd3,32'h1234,     1'b0,3'd0,1'b0,1'b0,4'h0,32'h0};
    tbl[3]  = '{1'b0,1'b0,5'd0,32'h0,        1'b0,6'b000000,1'b0,32'h0,        1'b1,
                1'b1,1'b0,5'd0,32'h0,        1'b0,3'd0,1'b0,1'b1,4'hF,32'h1234};
    tbl[4]  = '{1'b1,1'b1,5'd5,32'h0,        1'b1,6'b000000,1'b0,32'hDEADBEEF, 1'b0,
                1'b1,1'b0,5'd0,32'h0,        1'b0,3'd0,1'b0,1'b0,4'h0,32'h0};
    tbl[5]  = '{1'b0,1'b0,5'd0,32'h0,        1'b0,6'b000000,1'b0,32'hDEADBEEF, 1'b0,
                1'b1,1'b1,5'd5,32'hDEADBEEF, 1'b0,3'd0,1'b0,1'b0,4'h0,32'h0};
    tbl[6]  = '{1'b0,1'b0,5'd0,32'h0,        1'b0,6'b000000,1'b0,32'h0,        1'b1,
                1'b1,1'b0,5'd0,32'h0,        1'b0,3'd0,1'b0,1'b1,4'hF,32'hDEADBEEF};
    tbl[7]  = '{1'b1,1'b1,5'd7,32'h55,       1'b0,6'b100100,1'b0,32'h0,        1'b0,
                1'b1,1'b0,5'd0,32'h0,        1'b0,3'd0,1'b0,1'b0,4'h0,32'h0};
    tbl[8]  = '{1'b1,1'b1,5'd9,32'h99,       1'b0,6'b000000,1'b0,32'h0,        1'b0,
                1'b1,1'b0,5'd0,32'h0,        1'b1,3'd2,1'b0,1'b0,4'h0,32'h0};
    tbl[9]  = '{1'b0,1'b0,5'd0,32'h0,        1'b0,6'b000000,1'b0,32'h0,        1'b1,
                1'b1,1'b0,5'd0,32'h0,        1'b0,3'd0,1'b0,1'b1,4'h0,32'h55};
    tbl[10] = '{1'b1,1'b0,5'd0,32'h0,        1'b0,6'b000000,1'b1,32'h0,        1'b1,
                1'b1,1'b0,5'd0,32'h0,        1'b0,3'd0,1'b0,1'b0,4'h0,32'h0};
    tbl[11] = '{1'b1,1'b1,5'd4,32'h44,       1'b0,6'b000000,1'b0,32'h0,        1'b0,
                1'b1,1'b0,5'd0,32'h0,        1'b0,3'd0,1'b1,1'b0,4'h0,32'h0};
    tbl[12] = '{1'b0,1'b0,5'd0,32'h0,        1'b0,6'b000000,1'b0,32'h0,        1'b1,
                1'b1,1'b0,5'd0,32'h0,        1'b0,3'd0,1'b0,1'b1,4'h0,32'h0};

    for (int i = 0; i < 13; i++) begin
      set_instr(tbl[i].mv, 32'h1000 + 32'(4 * i), tbl[i].gw, tbl[i].wa, tbl[i].wd);
      mem_csr_re = tbl[i].csr; mem_exc = tbl[i].exc; mem_ertn = tbl[i].ertn;
      csr_rvalue = tbl[i].crv; trace_ready = tbl[i].tr;
      settle();
      chk($sformatf("v%0d_allowin", i), wb_allowin, tbl[i].e_allow);
      chk($sformatf("v%0d_rf_we", i), rf_we, tbl[i].e_rfwe);
      chk($sformatf("v%0d_wb_ex", i), wb_ex, tbl[i].e_ex);
      chk($sformatf("v%0d_ertn", i), ertn_flush, tbl[i].e_ertn);
      chk($sformatf("v%0d_tvalid", i), trace_valid, tbl[i].e_tv);
      if (tbl[i].e_rfwe) begin
        chk($sformatf("v%0d_rf_waddr", i), rf_waddr, tbl[i].e_wa);
        chk($sformatf("v%0d_rf_wdata", i), rf_wdata, tbl[i].e_wd);
      end
      if (tbl[i].e_ex) chk($sformatf("v%0d_exc_idx", i), wb_exc_idx, tbl[i].e_idx);
      if (tbl[i].e_tv) begin
        chk($sformatf("v%0d_trace_we", i), trace_we, tbl[i].e_twe);
        chk($sformatf("v%0d_trace_wdata", i), trace_wdata, tbl[i].e_twd);
      end
      advance();
    end
    csr_rvalue = 32'h0;

    // Backpressure: fifth instruction held until a single pop frees a slot.
    fill5();
    trace_ready = 1'b0;
    settle();
    chk("bp_held_allowin", wb_allowin, 1'b0);
    chk("bp_held_rf_we", rf_we, 1'b0);
    advance();
    trace_ready = 1'b1;
    settle();
    chk("bp_release_rf_we", rf_we, 1'b1);
    chk("bp_release_waddr", rf_waddr, 5'd5);
    chk("bp_release_allowin", wb_allowin, 1'b1);
    advance();
    trace_ready = 1'b0;
    settle();
    chk("bp_after_head", trace_wdata, 32'hA1);
    advance();
    pops = 0;
    trace_ready = 1'b1;
    for (int c = 0; c < 10 && trace_valid; c++) begin
      settle();
      pops++;
      advance();
    end
    settle();
    chk("bp_drain_count", pops, 4);
    chk("bp_drain_empty", trace_valid, 1'b0);
    advance();

    // Wrap-around: ten instructions while the consumer pops every other cycle.
    issued = 0; got_n = 0;
    for (int c = 0; c < 60 && (issued < 10 || m_wbv || tq.size() != 0); c++) begin
      set_instr(issued < 10, 32'h3000 + 32'(4 * issued), 1'b1, 5'(issued + 8),
                32'hC00 + 32'(issued));
      trace_ready = c[0];
      settle();
      if (trace_valid && trace_ready && got_n < 16) begin
        got[got_n] = trace_wdata;
        got_n++;
      end
      if (issued < 10 && m_allow) issued++;
      advance();
    end
    chk("wrap_count", got_n, 10);
    for (int j = 0; j < 10 && j < got_n; j++) chk($sformatf("wrap_order%0d", j), got[j], 32'hC00 + 32'(j));

    // Reset while full with an instruction waiting in WB.
    fill5();
    trace_ready = 1'b0;
    rst = 1'b1;
    settle();
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_wb_ex", wb_ex, 1'b0);
    chk("rst_ertn", ertn_flush, 1'b0);
    advance();
    rst = 1'b0;
    settle();
    chk("rst_tvalid", trace_valid, 1'b0);
    chk("rst_allowin", wb_allowin, 1'b1);
    advance();

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      set_instr($urandom_range(0, 2) != 0, $urandom, 1'($urandom), 5'($urandom), $urandom);
      mem_csr_re  = ($urandom_range(0, 3) == 0);
      mem_exc     = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd0;
      mem_ertn    = ($urandom_range(0, 15) == 0);
      csr_rvalue  = $urandom;
      trace_ready = ($urandom_range(0, 2) == 0);
      settle();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_retire_queue.md
WB_RETIRE_QUEUE -- requirements
Module: wb_retire_queue

Interface
REQ-001 Parameters (name, default, meaning): DATA_W, 32, GPR write-data width; AREG_W, 5, GPR address width; EXC_N, 6, exception-source count; TRACE_DEPTH, 4, retire-trace FIFO entries (power of two, >=2).
REQ-002 One clock; reset is synchronous and active-high; ports named clk and rst.
REQ-003 Ports (name direction width meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_valid  in  1  MEM presents an instruction
- wb_allowin  out  1  WB accepts an instruction this cycle
- mem_pc  in  32  instruction PC
- mem_gr_we  in  1  instruction writes a GPR
- mem_waddr  in  AREG_W  GPR destination
- mem_wdata  in  DATA_W  GPR data (non-CSR)
- mem_csr_re  in  1  result comes from CSR read
- mem_exc  in  EXC_N  exception flags; bit 0 has highest priority
- mem_ertn  in  1  instruction is ertn
- csr_rvalue  in  DATA_W  CSR read data (combinational, valid in retire cycle)
- rf_we  out  1  GPR write strobe
- rf_waddr  out  AREG_W  GPR write address
- rf_wdata  out  DATA_W  GPR write data
- wb_ex  out  1  exception commit pulse
- wb_exc_idx  out  clog2(EXC_N)  index of highest-priority exception
- ertn_flush  out  1  ertn commit pulse
- wb_pc  out  32  PC held in WB
- trace_valid  out  1  trace head entry available
- trace_ready  in  1  trace consumer pops head
- trace_pc  out  32  head PC
- trace_we  out  4  head write-enable (replicated rf_we)
- trace_waddr  out  AREG_W  head GPR address
- trace_wdata  out  DATA_W  head GPR data

Function
REQ-004 WB holds one instruction register (wb_valid plus all mem_* fields); it loads when mem_valid & wb_allowin.
REQ-005 trace_pop = trace_valid & trace_ready; retire_go = wb_valid & (count != TRACE_DEPTH | trace_pop).
REQ-006 wb_allowin = ~wb_valid | retire_go (combinational).
REQ-007 When wb_valid & ~retire_go, the WB register holds its contents and all commit outputs stay 0.
REQ-008 rf_wdata = held csr_re ? csr_rvalue : held wdata; rf_waddr = held waddr.
REQ-009 rf_we = retire_go & held gr_we & ~(|held exc): one cycle per instruction, never repeated.
REQ-010 wb_ex = retire_go & |held exc; wb_exc_idx = lowest set bit index of held exc, or 0 when none.
REQ-011 ertn_flush = retire_go & held ertn & ~(|held exc).
REQ-012 In a cycle where wb_ex or ertn_flush is 1, a concurrent mem_valid is discarded and wb_valid becomes 0 next cycle.
REQ-013 wb_pc = held PC whenever wb_valid, else don't-care.
REQ-014 Every retire_go pushes {pc, {4{rf_we}}, rf_waddr, rf_wdata} into the trace FIFO at the tail, including excepted instructions (trace_we = 0).
REQ-015 FIFO: count range 0..TRACE_DEPTH; head/tail pointers wrap modulo TRACE_DEPTH; trace_valid = (count != 0); trace_* show the head entry combinationally.
REQ-016 Push and pop in the same cycle leave count unchanged; this is legal when full (push occupies the slot freed by pop) and when count = 1.
REQ-017 A pop with count = 0 is impossible (trace_valid = 0); trace_ready is ignored when trace_valid = 0.
REQ-018 Back-to-back retires at one instruction per cycle are sustained while the FIFO is not full or is popped every cycle.

Reset
REQ-019 With rst = 1 at a clock edge: wb_valid, count, head, tail <= 0; next cycle trace_valid = 0, rf_we = wb_ex = ertn_flush = 0, wb_allowin = 1.
REQ-020 Reset mid-operation discards the held instruction and all FIFO contents without issuing any commit pulse; FIFO storage contents are not reset.

Verification
REQ-021 Single add: mem_gr_we = 1, waddr = 3, wdata = 0x1234, trace_ready = 1 -> next cycle rf_we = 1, rf_waddr = 3, rf_wdata = 0x1234; the cycle after that, trace_valid = 1 with trace_we = 4'hF.
REQ-022 CSR read: mem_csr_re = 1, csr_rvalue = 0xDEAD_BEEF -> rf_wdata = 0xDEADBEEF in the retire cycle and in the trace entry.
REQ-023 Exception priority: mem_exc = 6'b10_0100 with mem_gr_we = 1 -> wb_ex = 1, wb_exc_idx = 2, rf_we = 0; a concurrent mem_valid is dropped; trace entry has trace_we = 0.
REQ-024 Backpressure: trace_ready = 0 with 5 instructions issued (TRACE_DEPTH = 4) -> 4 retire, 5th is held with wb_allowin = 0; raise trace_ready for one cycle -> 5th retires in that same cycle and count stays 4.
REQ-025 Wrap-around: stream 10 instructions with trace_ready toggling every cycle -> trace output order and data exactly match issue order; no loss or duplication.
REQ-026 Reset while full and wb_valid = 1 -> no commit pulse; trace_valid = 0 and wb_allowin = 1 on the next cycle.
